// File: rtl/qsys_led_pkg.sv
// Shared constants for the RGB LED PWM controller: register map, ID magic, field positions.
// Latency: n/a (constants and helpers only).
// Backpressure: n/a.
package qsys_led_pkg;

    // Avalon word addresses
    localparam logic [4:0]  ADDR_ID        = 5'd0;
    localparam logic [4:0]  ADDR_CTRL      = 5'd1;
    localparam logic [4:0]  ADDR_PRESC     = 5'd2;
    localparam logic [4:0]  ADDR_BLINK     = 5'd3;
    localparam logic [4:0]  ADDR_DUTY_BASE = 5'd16;

    localparam logic [15:0] ID_MAGIC       = 16'h5A5A;

    // CTRL bit indices
    localparam int CTRL_EN_BIT    = 0;
    localparam int CTRL_INV_BIT   = 1;

    // DUTY_i field offsets
    localparam int DUTY_R_LSB     = 0;
    localparam int DUTY_G_LSB     = 8;
    localparam int DUTY_B_LSB     = 16;
    localparam int DUTY_BLINK_BIT = 24;

    // Word address of DUTY register for group idx
    function automatic logic [4:0] duty_addr(input int idx);
        return ADDR_DUTY_BASE + 5'(idx);
    endfunction

endpackage

// File: rtl/qsys_led_pwm_chan.sv
// One RGB group: pending/shadow duty, PWM comparators, blink gating, registered pin drivers.
// Latency: pins change one clock after i_pwm_cnt / shadow changes; duty writes reach the
//          comparators only at the next period boundary. Backpressure: none, writes always accepted.
// Ports: i_wr_vld/i_wr_dat write this group's DUTY word; i_boundary loads shadow from pending;
//        i_pwm_cnt/i_phase/i_enable/i_invert are shared timing/control; o_rd_dat is the pending
//        value for read-back; o_led_r/g/b are the registered pin levels.
module qsys_led_pwm_chan
    import qsys_led_pkg::*;
#(
    parameter int PWM_BITS = 8
) (
    input  logic                i_clk,
    input  logic                i_rst,
    input  logic                i_wr_vld,
    input  logic [31:0]         i_wr_dat,
    input  logic                i_boundary,
    input  logic [PWM_BITS-1:0] i_pwm_cnt,
    input  logic                i_phase,
    input  logic                i_enable,
    input  logic                i_invert,
    output logic [31:0]         o_rd_dat,
    output logic                o_led_r,
    output logic                o_led_g,
    output logic                o_led_b
);

    logic [PWM_BITS-1:0] r_pend_r, r_pend_g, r_pend_b;
    logic                r_pend_blink;
    logic [PWM_BITS-1:0] r_sh_r, r_sh_g, r_sh_b;
    logic                r_sh_blink;

    logic w_gate;
    logic w_raw_r, w_raw_g, w_raw_b;
    logic w_unused_wr;

    // Only the low PWM_BITS of each field and bit 24 are stored
    assign w_unused_wr = ^i_wr_dat;

    // Blink-enabled groups go dark during the off phase
    assign w_gate  = i_enable & ~(r_sh_blink & ~i_phase);
    assign w_raw_r = w_gate & (i_pwm_cnt < r_sh_r);
    assign w_raw_g = w_gate & (i_pwm_cnt < r_sh_g);
    assign w_raw_b = w_gate & (i_pwm_cnt < r_sh_b);

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_pend_r     <= '0;
            r_pend_g     <= '0;
            r_pend_b     <= '0;
            r_pend_blink <= 1'b0;
            r_sh_r       <= '0;
            r_sh_g       <= '0;
            r_sh_b       <= '0;
            r_sh_blink   <= 1'b0;
            o_led_r      <= 1'b0;
            o_led_g      <= 1'b0;
            o_led_b      <= 1'b0;
        end else begin
            if (i_wr_vld) begin
                r_pend_r     <= i_wr_dat[DUTY_R_LSB +: PWM_BITS];
                r_pend_g     <= i_wr_dat[DUTY_G_LSB +: PWM_BITS];
                r_pend_b     <= i_wr_dat[DUTY_B_LSB +: PWM_BITS];
                r_pend_blink <= i_wr_dat[DUTY_BLINK_BIT];
            end
            // Shadow takes the pre-write pending value if a write lands on the boundary
            if (i_boundary) begin
                r_sh_r     <= r_pend_r;
                r_sh_g     <= r_pend_g;
                r_sh_b     <= r_pend_b;
                r_sh_blink <= r_pend_blink;
            end
            o_led_r <= w_raw_r ^ i_invert;
            o_led_g <= w_raw_g ^ i_invert;
            o_led_b <= w_raw_b ^ i_invert;
        end
    end

    always_comb begin
        o_rd_dat                             = '0;
        o_rd_dat[DUTY_R_LSB +: PWM_BITS]     = r_pend_r;
        o_rd_dat[DUTY_G_LSB +: PWM_BITS]     = r_pend_g;
        o_rd_dat[DUTY_B_LSB +: PWM_BITS]     = r_pend_b;
        o_rd_dat[DUTY_BLINK_BIT]             = r_pend_blink;
    end

endmodule

// File: rtl/qsys_led_pwm.sv
// Avalon-MM RGB LED controller: NUM_LEDS groups, shared prescaler, PWM and blink counters.
// Latency: zero-latency combinational reads, writes take effect next clock; pins lag pwm_cnt by 1.
// Backpressure: waitrequest only while reset is asserted; otherwise every access completes at once.
// Ports: csi_MCLK_clk/rsi_MRST_reset clock and async high reset; avs_Ctrl_* Avalon slave;
//        coe_LED_R/G/B pin outputs, bit i = group i.
module qsys_led_pwm
    import qsys_led_pkg::*;
#(
    parameter int NUM_LEDS = 4,
    parameter int PWM_BITS = 8,
    parameter int PRESC_W  = 16
) (
    input  logic                csi_MCLK_clk,
    input  logic                rsi_MRST_reset,
    input  logic [4:0]          avs_Ctrl_address,
    input  logic                avs_Ctrl_read,
    output logic [31:0]         avs_Ctrl_readdata,
    input  logic                avs_Ctrl_write,
    input  logic [31:0]         avs_Ctrl_writedata,
    output logic                avs_Ctrl_waitrequest,
    output logic [NUM_LEDS-1:0] coe_LED_R,
    output logic [NUM_LEDS-1:0] coe_LED_G,
    output logic [NUM_LEDS-1:0] coe_LED_B
);

    logic                r_enable;
    logic                r_invert;
    logic [PRESC_W-1:0]  r_presc;
    logic [15:0]         r_blink;
    logic [PRESC_W-1:0]  r_pcnt;
    logic [PWM_BITS-1:0] r_pwm_cnt;
    logic [15:0]         r_bcnt;
    logic                r_phase;

    logic                w_tick;
    logic                w_boundary;
    logic                w_phase;
    logic [31:0]         w_duty_rd [NUM_LEDS];
    logic                w_unused_rd;

    assign avs_Ctrl_waitrequest = rsi_MRST_reset;
    assign w_unused_rd          = avs_Ctrl_read;

    // Equality compares: a limit lowered below the running count lets it wrap round
    assign w_tick     = r_enable && (r_pcnt == r_presc);
    assign w_boundary = w_tick && (r_pwm_cnt == '1);
    // BLINK=0 forces the on phase regardless of the stored phase bit
    assign w_phase    = (r_blink == 16'd0) ? 1'b1 : r_phase;

    always_ff @(posedge csi_MCLK_clk or posedge rsi_MRST_reset) begin
        if (rsi_MRST_reset) begin
            r_enable  <= 1'b0;
            r_invert  <= 1'b0;
            r_presc   <= '0;
            r_blink   <= '0;
            r_pcnt    <= '0;
            r_pwm_cnt <= '0;
            r_bcnt    <= '0;
            r_phase   <= 1'b0;
        end else begin
            if (avs_Ctrl_write) begin
                case (avs_Ctrl_address)
                    ADDR_CTRL: begin
                        r_enable <= avs_Ctrl_writedata[CTRL_EN_BIT];
                        r_invert <= avs_Ctrl_writedata[CTRL_INV_BIT];
                    end
                    ADDR_PRESC: r_presc <= avs_Ctrl_writedata[PRESC_W-1:0];
                    ADDR_BLINK: r_blink <= avs_Ctrl_writedata[15:0];
                    default: ;
                endcase
            end
            if (r_enable) begin
                r_pcnt <= w_tick ? '0 : r_pcnt + PRESC_W'(1);
            end
            if (w_tick) begin
                r_pwm_cnt <= r_pwm_cnt + PWM_BITS'(1);
            end
            if (w_boundary) begin
                if (r_blink == 16'd0) begin
                    r_bcnt  <= '0;
                    r_phase <= 1'b1;
                end else if (r_bcnt == r_blink - 16'd1) begin
                    r_bcnt  <= '0;
                    r_phase <= ~r_phase;
                end else begin
                    r_bcnt  <= r_bcnt + 16'd1;
                end
            end
        end
    end

    always_comb begin
        avs_Ctrl_readdata = '0;
        case (avs_Ctrl_address)
            ADDR_ID:    avs_Ctrl_readdata = {ID_MAGIC, 8'(PWM_BITS), 8'(NUM_LEDS)};
            ADDR_CTRL: begin
                avs_Ctrl_readdata[CTRL_EN_BIT]  = r_enable;
                avs_Ctrl_readdata[CTRL_INV_BIT] = r_invert;
            end
            ADDR_PRESC: avs_Ctrl_readdata[PRESC_W-1:0] = r_presc;
            ADDR_BLINK: avs_Ctrl_readdata[15:0]        = r_blink;
            default: ;
        endcase
        for (int i = 0; i < NUM_LEDS; i++) begin
            if (avs_Ctrl_address == duty_addr(i)) begin
                avs_Ctrl_readdata = w_duty_rd[i];
            end
        end
    end

    for (genvar gi = 0; gi < NUM_LEDS; gi++) begin : g_chan
        qsys_led_pwm_chan #(
            .PWM_BITS (PWM_BITS)
        ) u_chan (
            .i_clk      (csi_MCLK_clk),
            .i_rst      (rsi_MRST_reset),
            .i_wr_vld   (avs_Ctrl_write && (avs_Ctrl_address == duty_addr(gi))),
            .i_wr_dat   (avs_Ctrl_writedata),
            .i_boundary (w_boundary),
            .i_pwm_cnt  (r_pwm_cnt),
            .i_phase    (w_phase),
            .i_enable   (r_enable),
            .i_invert   (r_invert),
            .o_rd_dat   (w_duty_rd[gi]),
            .o_led_r    (coe_LED_R[gi]),
            .o_led_g    (coe_LED_G[gi]),
            .o_led_b    (coe_LED_B[gi])
        );
    end

endmodule

// File: tb/tb_qsys_led_pwm.sv
// Self-checking bench for qsys_led_pwm against a rule-level reference model.
// Latency: n/a. Backpressure: n/a.
module tb_qsys_led_pwm;

    localparam int NL = 4;
    localparam int PB = 8;
    localparam int PW = 16;
    localparam int P  = 1 << PB;
    localparam int M  = P - 1;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic [4:0]    addr = '0;
    logic          rd = 1'b0;
    logic          wr = 1'b0;
    logic [31:0]   wdata = '0;
    logic [31:0]   rdata;
    logic          waitreq;
    logic [NL-1:0] led_r, led_g, led_b;

    always #5 clk = ~clk;

    qsys_led_pwm #(.NUM_LEDS(NL), .PWM_BITS(PB), .PRESC_W(PW)) dut (
        .csi_MCLK_clk         (clk),
        .rsi_MRST_reset       (rst),
        .avs_Ctrl_address     (addr),
        .avs_Ctrl_read        (rd),
        .avs_Ctrl_readdata    (rdata),
        .avs_Ctrl_write       (wr),
        .avs_Ctrl_writedata   (wdata),
        .avs_Ctrl_waitrequest (waitreq),
        .coe_LED_R            (led_r),
        .coe_LED_G            (led_g),
        .coe_LED_B            (led_b)
    );

    int checks = 0;
    int errors = 0;

    // Reference model state
    int            m_en, m_inv, m_presc, m_blink, m_pcnt, m_pwm, m_bcnt, m_phase;
    logic [31:0]   m_pend [NL];
    logic [31:0]   m_shad [NL];
    logic [NL-1:0] m_r, m_g, m_b;

    function automatic int fld(input logic [31:0] w, input int lsb);
        return int'((w >> lsb) & 32'(M));
    endfunction

    function automatic logic [31:0] stored(input logic [31:0] w);
        return (w & 32'(M)) | (w & (32'(M) << 8)) | (w & (32'(M) << 16)) | (w & 32'h0100_0000);
    endfunction

    task automatic model_reset();
        m_en = 0; m_inv = 0; m_presc = 0; m_blink = 0;
        m_pcnt = 0; m_pwm = 0; m_bcnt = 0; m_phase = 0;
        for (int g = 0; g < NL; g++) begin
            m_pend[g] = '0;
            m_shad[g] = '0;
        end
        m_r = '0; m_g = '0; m_b = '0;
    endtask

    // Advance the model by one clock using the bus inputs present at the edge
    task automatic model_step();
        int  ph;
        bit  on, tick, bnd;
        if (rst) begin
            model_reset();
            return;
        end
        ph = (m_blink == 0) ? 1 : m_phase;
        for (int g = 0; g < NL; g++) begin
            on = (m_en != 0) && !(m_shad[g][24] && ph == 0);
            m_r[g] = (on && m_pwm < fld(m_shad[g], 0))  ^ (m_inv != 0);
            m_g[g] = (on && m_pwm < fld(m_shad[g], 8))  ^ (m_inv != 0);
            m_b[g] = (on && m_pwm < fld(m_shad[g], 16)) ^ (m_inv != 0);
        end
        tick = (m_en != 0) && (m_pcnt == m_presc);
        bnd  = tick && (m_pwm == M);
        if (m_en != 0) m_pcnt = tick ? 0 : (m_pcnt + 1) % (1 << PW);
        if (bnd) begin
            for (int g = 0; g < NL; g++) m_shad[g] = m_pend[g];
            if (m_blink == 0) begin
                m_bcnt = 0; m_phase = 1;
            end else if (m_bcnt == m_blink - 1) begin
                m_bcnt = 0; m_phase = 1 - m_phase;
            end else begin
                m_bcnt = (m_bcnt + 1) % 65536;
            end
        end
        if (tick) m_pwm = (m_pwm + 1) % P;
        if (wr) begin
            if (addr == 5'd1) begin
                m_en = int'(wdata[0]); m_inv = int'(wdata[1]);
            end
            if (addr == 5'd2) m_presc = int'(wdata[PW-1:0]);
            if (addr == 5'd3) m_blink = int'(wdata[15:0]);
            for (int g = 0; g < NL; g++)
                if (int'(addr) == 16 + g) m_pend[g] = stored(wdata);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        model_step();
        #1;
    endtask

    task automatic bus_write(input logic [4:0] a, input logic [31:0] d);
        addr = a; wdata = d; wr = 1'b1;
        cyc();
        wr = 1'b0;
    endtask

    // Wait (bounded) until the next edge restarts the prescaler so a PRESC change never wraps
    task automatic align_presc();
        for (int i = 0; i < 70000 && m_pcnt != m_presc; i++) cyc();
    endtask

    task automatic test_reset();
        logic [4:0] ra [5];
        ra = '{5'd1, 5'd2, 5'd3, 5'd16, 5'd19};
        #1 rst = 1'b1;
        model_reset();
        #2;
        checks++;
        if (waitreq !== 1'b1) begin
            errors++; $display("FAIL reset_waitreq: got %b expected 1", waitreq);
        end
        checks++;
        if ({led_r, led_g, led_b} !== '0) begin
            errors++; $display("FAIL reset_pins: got %h expected 0", {led_r, led_g, led_b});
        end
        repeat (3) cyc();
        rst = 1'b0;
        #1;
        checks++;
        if (waitreq !== 1'b0) begin
            errors++; $display("FAIL release_waitreq: got %b expected 0", waitreq);
        end
        addr = 5'd0; rd = 1'b1; #1;
        checks++;
        if (rdata !== 32'h5A5A0804) begin
            errors++; $display("FAIL id_read: got %h expected 5a5a0804", rdata);
        end
        for (int i = 0; i < 5; i++) begin
            addr = ra[i]; #1;
            checks++;
            if (rdata !== 32'h0) begin
                errors++; $display("FAIL reset_reg_%0d: got %h expected 0", ra[i], rdata);
            end
        end
        rd = 1'b0;
        repeat (4) begin
            cyc();
            checks++;
            if ({led_r, led_g, led_b} !== {m_r, m_g, m_b}) begin
                errors++; $display("FAIL idle_pins: got %h expected %h", {led_r, led_g, led_b}, {m_r, m_g, m_b});
            end
        end
    endtask

    task automatic test_basic_pwm();
        int cr, cg, cb, co;
        bus_write(5'd16, 32'h00FF4000);
        bus_write(5'd1, 32'h1);
        repeat (600) begin
            cyc();
            checks++;
            if ({led_r, led_g, led_b} !== {m_r, m_g, m_b}) begin
                errors++; $display("FAIL basic_pins: got %h expected %h", {led_r, led_g, led_b}, {m_r, m_g, m_b});
            end
        end
        cr = 0; cg = 0; cb = 0; co = 0;
        repeat (256) begin
            cyc();
            cr += int'(led_r[0]); cg += int'(led_g[0]); cb += int'(led_b[0]);
            co += int'(|{led_r[NL-1:1], led_g[NL-1:1], led_b[NL-1:1]});
        end
        checks++;
        if (cr != 0 || cg != 64 || cb != 255 || co != 0) begin
            errors++; $display("FAIL basic_duty_count: got r=%0d g=%0d b=%0d other=%0d expected 0 64 255 0", cr, cg, cb, co);
        end
    endtask

    task automatic test_prescaler();
        int cg, cb;
        align_presc();
        bus_write(5'd2, 32'd3);
        repeat (1100) begin
            cyc();
            checks++;
            if ({led_r, led_g, led_b} !== {m_r, m_g, m_b}) begin
                errors++; $display("FAIL presc_pins: got %h expected %h", {led_r, led_g, led_b}, {m_r, m_g, m_b});
            end
        end
        cg = 0; cb = 0;
        repeat (1024) begin
            cyc();
            cg += int'(led_g[0]); cb += int'(led_b[0]);
        end
        checks++;
        if (cg != 256 || cb != 1020) begin
            errors++; $display("FAIL presc_duty_count: got g=%0d b=%0d expected 256 1020", cg, cb);
        end
    endtask

    task automatic test_shadow_update();
        logic [31:0] d;
        align_presc();
        bus_write(5'd2, 32'd0);
        bus_write(5'd17, {8'h00, 8'($urandom_range(1, 255)), 8'($urandom_range(1, 255)), 8'($urandom_range(1, 255))});
        for (int i = 0; i < 2 * P + 50; i++) cyc();
        // Mid-period write, then a write landing on the boundary edge
        for (int k = 0; k < 2; k++) begin
            for (int i = 0; i < 600 && m_pwm != ((k == 0) ? 100 : M); i++) cyc();
            d = $urandom;
            bus_write(5'd17, d);
            addr = 5'd17; #1;
            checks++;
            if (rdata !== stored(d)) begin
                errors++; $display("FAIL duty_readback_%0d: got %h expected %h", k, rdata, stored(d));
            end
            repeat (400) begin
                cyc();
                checks++;
                if ({led_r, led_g, led_b} !== {m_r, m_g, m_b}) begin
                    errors++; $display("FAIL shadow_pins: got %h expected %h", {led_r, led_g, led_b}, {m_r, m_g, m_b});
                end
            end
        end
    endtask

    task automatic test_blink();
        int c2;
        bus_write(5'd3, 32'd2);
        bus_write(5'd18, 32'h01FFFFFF);
        repeat (3 * P) begin
            cyc();
            checks++;
            if ({led_r, led_g, led_b} !== {m_r, m_g, m_b}) begin
                errors++; $display("FAIL blink_pins: got %h expected %h", {led_r, led_g, led_b}, {m_r, m_g, m_b});
            end
        end
        c2 = 0;
        repeat (4 * P) begin
            cyc();
            c2 += int'(led_r[2]);
        end
        checks++;
        if (c2 != 2 * M) begin
            errors++; $display("FAIL blink_on_count: got %0d expected %0d", c2, 2 * M);
        end
        bus_write(5'd3, 32'd0);
        repeat (2 * P) cyc();
        c2 = 0;
        repeat (P) begin
            cyc();
            c2 += int'(led_r[2]);
        end
        checks++;
        if (c2 != M) begin
            errors++; $display("FAIL blink_off_steady: got %0d expected %0d", c2, M);
        end
    endtask

    task automatic test_unmapped();
        logic [4:0] ua [4];
        ua = '{5'd5, 5'd15, 5'd20, 5'd31};
        bus_write(5'd0, 32'hFFFFFFFF);
        bus_write(5'd20, 32'hFFFFFFFF);
        addr = 5'd0; #1;
        checks++;
        if (rdata !== 32'h5A5A0804) begin
            errors++; $display("FAIL id_after_write: got %h expected 5a5a0804", rdata);
        end
        for (int i = 0; i < 4; i++) begin
            addr = ua[i]; #1;
            checks++;
            if (rdata !== 32'h0) begin
                errors++; $display("FAIL unmapped_%0d: got %h expected 0", ua[i], rdata);
            end
        end
        addr = 5'd16; #1;
        checks++;
        if (rdata !== m_pend[0]) begin
            errors++; $display("FAIL duty0_untouched: got %h expected %h", rdata, m_pend[0]);
        end
    endtask

    task automatic test_random();
        logic [31:0] d, ctrl;
        int          g;
        for (int r = 0; r < 8; r++) begin
            ctrl = {30'd0, 1'($urandom), 1'b1};
            bus_write(5'd1, ctrl);
            align_presc();
            bus_write(5'd2, 32'($urandom_range(0, 2)));
            bus_write(5'd3, 32'($urandom_range(0, 3)));
            repeat (2) begin
                g = int'($urandom_range(0, NL - 1));
                d = $urandom;
                bus_write(5'(16 + g), d);
                addr = 5'(16 + g); #1;
                checks++;
                if (rdata !== stored(d)) begin
                    errors++; $display("FAIL rand_readback_g%0d: got %h expected %h", g, rdata, stored(d));
                end
            end
            if ($urandom_range(0, 3) == 0) ctrl[0] = 1'b0;
            bus_write(5'd1, ctrl);
            addr = 5'd1; #1;
            checks++;
            if (rdata !== ctrl) begin
                errors++; $display("FAIL rand_ctrl_readback: got %h expected %h", rdata, ctrl);
            end
            repeat ($urandom_range(300, 900)) begin
                cyc();
                checks++;
                if ({led_r, led_g, led_b} !== {m_r, m_g, m_b}) begin
                    errors++; $display("FAIL rand_pins: got %h expected %h", {led_r, led_g, led_b}, {m_r, m_g, m_b});
                end
            end
        end
    endtask

    task automatic test_async_reset();
        bus_write(5'd1, 32'h3);
        repeat (50) cyc();
        #2 rst = 1'b1;
        model_reset();
        #1;
        checks++;
        if ({led_r, led_g, led_b} !== '0 || waitreq !== 1'b1) begin
            errors++; $display("FAIL async_reset: got pins=%h wait=%b expected 0 1", {led_r, led_g, led_b}, waitreq);
        end
        repeat (3) cyc();
        rst = 1'b0;
        for (int a = 1; a < 24; a++) begin
            if (a > 3 && a < 16) continue;
            addr = 5'(a); #1;
            checks++;
            if (rdata !== 32'h0) begin
                errors++; $display("FAIL post_reset_reg_%0d: got %h expected 0", a, rdata);
            end
        end
        repeat (20) begin
            cyc();
            checks++;
            if ({led_r, led_g, led_b} !== '0) begin
                errors++; $display("FAIL post_reset_pins: got %h expected 0", {led_r, led_g, led_b});
            end
        end
    endtask

    initial begin
        model_reset();
        test_reset();
        test_basic_pwm();
        test_prescaler();
        test_shadow_update();
        test_blink();
        test_unmapped();
        test_random();
        test_async_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/qsys_led_pwm.md
Name: qsys_led_pwm

Overview:
Parametrised RGB LED controller on an Avalon-MM slave; next generation of the single-register LED test block. Drives NUM_LEDS RGB groups, each colour with PWM_BITS-wide duty, a shared programmable prescaler, per-group blink, and glitch-free duty update at PWM-period boundaries. Sits in the Qsys system between the MCU bus bridge and the front-panel LED pins.

Parameters:
NUM_LEDS, 4, number of RGB groups (1..16)
PWM_BITS, 8, duty/PWM counter width (4..8)
PRESC_W, 16, prescaler width

Ports:
csi_MCLK_clk  in  1  system clock
rsi_MRST_reset  in  1  reset, asynchronous, active-high
avs_Ctrl_address  in  5  word address
avs_Ctrl_read  in  1  read strobe
avs_Ctrl_readdata  out  32  read data
avs_Ctrl_write  in  1  write strobe
avs_Ctrl_writedata  in  32  write data
avs_Ctrl_waitrequest  out  1  equals rsi_MRST_reset
coe_LED_R  out  NUM_LEDS  red outputs, bit i = group i
coe_LED_G  out  NUM_LEDS  green outputs
coe_LED_B  out  NUM_LEDS  blue outputs

Behaviour:
- Reset (async, active-high): all registers to reset values below; all coe_LED_* = 0; counters = 0; blink phase = 0.
- Register map (word address): 0 ID (RO) = {16'h5A5A, 8'(PWM_BITS), 8'(NUM_LEDS)}; 1 CTRL [0]=enable (reset 0), [1]=invert outputs (reset 0); 2 PRESC [PRESC_W-1:0] (reset 0); 3 BLINK [15:0] half-period in PWM periods (reset 0); 16+i DUTY_i: [7:0]=R, [15:8]=G, [23:16]=B, [24]=blink_en (reset 0). Only low PWM_BITS of each duty field are stored.
- Read: combinational readdata from address, zero-latency; unused bits and unmapped addresses read 0. DUTY reads return the written (pending) value, not the shadow.
- Write: captured on rising clk when write=1; writes to ID/unmapped addresses ignored.
- Prescaler: pcnt counts 0..PRESC, then tick=1 for one cycle and pcnt<=0. PRESC=0 → tick every cycle. Counts only when enable=1; enable=0 holds pcnt, pwm_cnt, blink state.
- PWM counter pwm_cnt (PWM_BITS) increments on tick, wraps at all-ones → 0; wrap tick = period boundary.
- Shadow: on period boundary, all pending DUTY_i copy into shadow registers; comparison uses shadow only. Write coinciding with boundary tick: new value goes to pending; shadow takes the old pending value (no same-cycle bypass).
- Channel raw = (pwm_cnt < shadow_duty). Duty 0 = always off; duty all-ones = on (2^PWM_BITS-1)/2^PWM_BITS.
- Blink: bcnt counts period boundaries; when bcnt == BLINK-1, bcnt<=0 and phase toggles. BLINK=0 → phase held at 1 (on). If group blink_en=1 and phase=0, group outputs raw forced 0.
- Output = registered (raw & enable_gate) ^ invert; one-cycle latency from pwm_cnt change to pin. enable=0 → all raw 0 (pins = invert).
- Changing PRESC or BLINK mid-count: takes effect at next compare; if counter already > new limit, it continues to wrap naturally (PRESC_W/16-bit) — documented, not an error.

Decomposition:
- Package qsys_led_pkg: register address constants, ID magic 16'h5A5A, CTRL bit indices, DUTY field offsets.
- One sub-module qsys_led_pwm_chan (pending/shadow duty for one RGB group, comparators, blink gating, output register), instantiated NUM_LEDS times via generate; prescaler, period/blink counters and bus decode in top.

Test Plan:
- Reset then read addr 0 → 32'h5A5A0804; all pins 0; waitrequest=1 during reset, 0 after.
- enable=1, PRESC=0, DUTY_0=0x00FF4000 → R0 always 0, G0 high 64 of every 256 cycles, B0 high 255/256; other groups 0.
- PRESC=3 → pwm_cnt advances every 4 clocks; G0 high duration 256 cycles per 1024-cycle period.
- Write DUTY_1 mid-period → pin waveform unchanged until next pwm_cnt wrap, new duty from that period; read-back shows new value immediately.
- BLINK=2, DUTY_2 blink_en=1, full duty → group 2 on 2 periods, off 2 periods; BLINK=0 → steady on.
- Assert reset mid-PWM with invert=1 → pins drop to 0 asynchronously, all registers back to defaults.
